// File: rtl/delay_pkg.sv
// Shared types and helpers for the delay_line_ram block.
// Optional RAM clear-on-reset is controlled by the DELAY_CLEAR_EN macro in delay_line_ram.
package delay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        CLR
    } state_t;

    // Channel-index width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned depth);
        if (req == 0) begin
            return 1;
        end else if (req > depth) begin
            return depth;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, 1-cycle read latency.
module delay_ram #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned WORDS = 8192
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(WORDS)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/delay_line_ram.sv
// Multi-channel BRAM-backed circular delay line, one sample per channel per transaction.
// Define DELAY_CLEAR_EN to zero the RAM after reset instead of masking unwritten history.
module delay_line_ram
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ch_bits(CHANNELS)-1:0]  in_ch,
    input  logic [WIDTH-1:0]              in,
    input  logic                          cfg_we,
    input  logic [ch_bits(CHANNELS)-1:0]  cfg_ch,
    input  logic [$clog2(DEPTH):0]        cfg_delay,
    output logic                          out_valid,
    output logic [ch_bits(CHANNELS)-1:0]  out_ch,
    output logic [WIDTH-1:0]              out
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = ch_bits(CHANNELS);
    localparam int unsigned DW    = AW + 1;
    localparam int unsigned WORDS = CHANNELS * DEPTH;
    localparam int unsigned RA    = $clog2(WORDS);

    state_t state, state_next;

    logic [AW-1:0]    wr_ptr [CHANNELS];
    logic [DW-1:0]    dly    [CHANNELS];
`ifndef DELAY_CLEAR_EN
    logic [DW-1:0]    fill   [CHANNELS];
`else
    logic [RA-1:0]    clr_addr;
`endif

    logic [WIDTH-1:0] lat_data;
    logic [CW-1:0]    lat_ch;
    logic [DW-1:0]    lat_d;
    logic [AW-1:0]    rd_ptr;

    logic             ram_we;
    logic             ram_re;
    logic [RA-1:0]    ram_waddr;
    logic [RA-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    // d == DEPTH wraps to the write address itself; the read in RD precedes the write in WR.
    assign rd_ptr = wr_ptr[lat_ch] - lat_d[AW-1:0];

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_waddr  = RA'({lat_ch, wr_ptr[lat_ch]});
        ram_raddr  = RA'({lat_ch, rd_ptr});
        ram_wdata  = lat_data;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RD;
                end
            end
            RD: begin
                ram_re     = 1'b1;
                state_next = WR;
            end
            WR: begin
                ram_we     = 1'b1;
                state_next = IDLE;
            end
            CLR: begin
`ifdef DELAY_CLEAR_EN
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
                if (clr_addr == RA'(WORDS - 1)) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
`ifdef DELAY_CLEAR_EN
            state <= CLR;
`else
            state <= IDLE;
`endif
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                dly[i]    <= DW'(DEPTH);
`ifndef DELAY_CLEAR_EN
                fill[i]   <= '0;
`endif
            end
`ifdef DELAY_CLEAR_EN
            clr_addr  <= '0;
`endif
            lat_data  <= '0;
            lat_ch    <= '0;
            lat_d     <= '0;
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // A same-cycle accept latches the pre-write delay value.
            if (cfg_we) begin
                dly[cfg_ch] <= DW'(clamp_delay(32'(cfg_delay), DEPTH));
            end
            if (state == IDLE && in_valid) begin
                lat_data <= in;
                lat_ch   <= in_ch;
                lat_d    <= dly[in_ch];
            end
            if (state == WR) begin
                wr_ptr[lat_ch] <= wr_ptr[lat_ch] + 1'b1;
`ifndef DELAY_CLEAR_EN
                if (fill[lat_ch] != DW'(DEPTH)) begin
                    fill[lat_ch] <= fill[lat_ch] + 1'b1;
                end
                out <= (fill[lat_ch] < lat_d) ? '0 : ram_rdata;
`else
                out <= ram_rdata;
`endif
                out_ch    <= lat_ch;
                out_valid <= 1'b1;
            end
`ifdef DELAY_CLEAR_EN
            if (state == CLR) begin
                clr_addr <= clr_addr + 1'b1;
            end
`endif
        end
    end

    delay_ram #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_delay_line_ram.sv
// Directed self-checking bench for delay_line_ram (WIDTH=16, DEPTH=8, CHANNELS=2).
// Honours DELAY_CLEAR_EN when the design is built with it.
module tb_delay_line_ram;

    localparam int unsigned W = 16;
    localparam int unsigned D = 8;
    localparam int unsigned C = 2;

`ifdef DELAY_CLEAR_EN
    localparam int unsigned CLR_CYC = C * D;
    localparam logic        RST_RDY = 1'b0;
`else
    localparam int unsigned CLR_CYC = 0;
    localparam logic        RST_RDY = 1'b1;
`endif

    logic         clk       = 1'b0;
    logic         rstn      = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [0:0]   in_ch     = '0;
    logic [W-1:0] din       = '0;
    logic         cfg_we    = 1'b0;
    logic [0:0]   cfg_ch    = '0;
    logic [3:0]   cfg_delay = '0;
    logic         out_valid;
    logic [0:0]   out_ch;
    logic [W-1:0] dout;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    delay_line_ram #(
        .WIDTH    (W),
        .DEPTH    (D),
        .CHANNELS (C)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in        (din),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out       (dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        int unsigned cnt;
        cnt  = 0;
        rstn = 1'b0;
        #1;
        check("rst_ready", in_ready, RST_RDY);
        check("rst_valid", out_valid, 0);
        check("rst_out", dout, 0);
        check("rst_ch", out_ch, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        while (!in_ready && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("ready_after_rst", cnt, CLR_CYC);
    endtask

    task automatic cfg(input logic ch, input logic [3:0] d);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_delay = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic ch, input logic [W-1:0] val, input logic [W-1:0] exp,
                        input logic cw, input logic [3:0] cd, input string tag);
        int unsigned n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check({tag, "_ready_timeout"}, in_ready, 1);
        in_valid  = 1'b1;
        in_ch     = ch;
        din       = val;
        cfg_we    = cw;
        cfg_ch    = ch;
        cfg_delay = cd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check({tag, "_rdy_k1"}, in_ready, 0);
        check({tag, "_ov_k1"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_rdy_k2"}, in_ready, 0);
        check({tag, "_ov_k2"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_ov_k3"}, out_valid, 1);
        check({tag, "_out"}, dout, exp);
        check({tag, "_ch"}, out_ch, ch);
        check({tag, "_rdy_k3"}, in_ready, 1);
    endtask

    task automatic push_s(input logic ch, input logic [W-1:0] val, input logic [W-1:0] exp,
                          input string tag);
        push(ch, val, exp, 1'b0, 4'd0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] t1_in  [5] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
        logic [W-1:0] t1_exp [5] = '{16'd0, 16'd0, 16'd0, 16'd10, 16'd20};
        logic         t3_ch  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] t3_in  [6] = '{16'd100, 16'd200, 16'd101, 16'd201, 16'd102, 16'd202};
        logic [W-1:0] t3_exp [6] = '{16'd0, 16'd0, 16'd0, 16'd200, 16'd100, 16'd201};

        #2;
        // basic delay of 3
        do_reset();
        cfg(1'b0, 4'd3);
        for (int i = 0; i < 5; i++) begin
            push_s(1'b0, t1_in[i], t1_exp[i], $sformatf("t1_%0d", i));
        end

        // full depth: wrap and read-before-write
        do_reset();
        cfg(1'b0, 4'd8);
        for (int i = 1; i <= 20; i++) begin
            push_s(1'b0, W'(i), (i > 8) ? W'(i - 8) : '0, $sformatf("t2_%0d", i));
        end

        // interleaved channels
        do_reset();
        cfg(1'b0, 4'd2);
        cfg(1'b1, 4'd1);
        for (int i = 0; i < 6; i++) begin
            push_s(t3_ch[i], t3_in[i], t3_exp[i], $sformatf("t3_%0d", i));
        end

        // clamps and same-cycle config
        do_reset();
        cfg(1'b1, 4'd0);
        push_s(1'b1, 16'd7, 16'd0, "t4_d0_a");
        push_s(1'b1, 16'd8, 16'd7, "t4_d0_b");
        push_s(1'b1, 16'd9, 16'd8, "t4_d0_c");
        cfg(1'b1, 4'd15);
        for (int i = 11; i <= 15; i++) begin
            push_s(1'b1, W'(i), '0, $sformatf("t4_d15_%0d", i));
        end
        push_s(1'b1, 16'd16, 16'd7, "t4_d15_16");
        push_s(1'b1, 16'd17, 16'd8, "t4_d15_17");
        cfg(1'b0, 4'd1);
        push_s(1'b0, 16'd21, 16'd0, "t4_cw_a");
        push_s(1'b0, 16'd22, 16'd21, "t4_cw_b");
        push(1'b0, 16'd23, 16'd22, 1'b1, 4'd2, "t4_cw_same");
        push_s(1'b0, 16'd24, 16'd22, "t4_cw_new");

        // reset during RD
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            push_s(1'b0, W'(i), (i > 8) ? W'(i - 8) : '0, $sformatf("t5_%0d", i));
        end
        in_valid = 1'b1;
        in_ch    = 1'b0;
        din      = 16'd99;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t5_mid_rd_rdy", in_ready, 0);
        check("t5_pre_rst_out", dout, 1);
        do_reset();
        cfg(1'b0, 4'd1);
        push_s(1'b0, 16'd7, 16'd0, "t5_post_a");
        push_s(1'b0, 16'd8, 16'd7, "t5_post_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
